// File: rtl/dsp_mult_lane_array_if.sv
// Bundle between a matrix engine (master) and the DSP multiplier lane array (slave).
//   dsp_ce        global clock-enable for every pipeline stage
//   dsp_clr       synchronous clear of data registers, valid pipe and accumulators
//   dsp_a0/dsp_b0 per-lane unsigned operands
//   dsp_out       per-lane P-register
//   dsp_out_valid P-registers hold products of real sampled operands
//   dsp_acc_load  load instead of accumulate (DSP_ACC_EN builds only)
//   dsp_acc_ovf   sticky per-lane accumulator carry-out (DSP_ACC_EN builds only)
// Optional feature macro: DSP_ACC_EN.
interface dsp_mult_lane_array_if #(
  parameter int unsigned NUM_LANES = 5,
  parameter int unsigned A_W       = 18,
  parameter int unsigned B_W       = 18,
  parameter int unsigned OUT_W     = 37
);
  logic                            dsp_ce;
  logic                            dsp_clr;
  logic [NUM_LANES-1:0][A_W-1:0]   dsp_a0;
  logic [NUM_LANES-1:0][B_W-1:0]   dsp_b0;
  logic [NUM_LANES-1:0][OUT_W-1:0] dsp_out;
  logic                            dsp_out_valid;
`ifdef DSP_ACC_EN
  logic                            dsp_acc_load;
  logic [NUM_LANES-1:0]            dsp_acc_ovf;

  modport master (
    output dsp_ce, dsp_clr, dsp_a0, dsp_b0, dsp_acc_load,
    input  dsp_out, dsp_out_valid, dsp_acc_ovf
  );

  modport slave (
    input  dsp_ce, dsp_clr, dsp_a0, dsp_b0, dsp_acc_load,
    output dsp_out, dsp_out_valid, dsp_acc_ovf
  );
`else
  modport master (
    output dsp_ce, dsp_clr, dsp_a0, dsp_b0,
    input  dsp_out, dsp_out_valid
  );

  modport slave (
    input  dsp_ce, dsp_clr, dsp_a0, dsp_b0,
    output dsp_out, dsp_out_valid
  );
`endif
endinterface

// File: rtl/dsp_mult_lane_array.sv
// Array of independent unsigned multiplier lanes modelling an A/B-reg -> M-reg -> P-reg
// DSP pipeline. All stages share one clock-enable, one synchronous clear and one valid pipe.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   dsp  slave side of dsp_mult_lane_array_if (operands in, P-registers and valid out)
// Optional feature macro: DSP_ACC_EN adds a per-lane post-adder in the P stage with a
// sticky carry-out flag; without it the P stage is a plain zero-extension of M.
module dsp_mult_lane_array #(
  parameter int unsigned NUM_LANES = 5,
  parameter int unsigned A_W       = 18,
  parameter int unsigned B_W       = 18,
  parameter int unsigned OUT_W     = 37
) (
  input  logic                 clk,
  input  logic                 rst,
  dsp_mult_lane_array_if.slave dsp
);

  localparam int unsigned M_W = A_W + B_W;

  logic [NUM_LANES-1:0][A_W-1:0]   a_q;
  logic [NUM_LANES-1:0][B_W-1:0]   b_q;
  logic [NUM_LANES-1:0][M_W-1:0]   m_q, m_d;
  logic [NUM_LANES-1:0][OUT_W-1:0] p_q, p_d;
  logic [2:0]                      vpipe_q;

`ifdef DSP_ACC_EN
  logic [NUM_LANES-1:0]            ovf_q, ovf_d;
  logic [NUM_LANES-1:0][OUT_W:0]   acc_sum;
`endif

  always_comb begin
    m_d = m_q;
    p_d = p_q;
`ifdef DSP_ACC_EN
    ovf_d   = ovf_q;
    acc_sum = '0;
`endif
    for (int l = 0; l < NUM_LANES; l++) begin
      m_d[l] = M_W'(a_q[l]) * M_W'(b_q[l]);
`ifdef DSP_ACC_EN
      // One extra bit captures the carry-out of the modulo-2^OUT_W accumulation.
      acc_sum[l] = {1'b0, p_q[l]} + (OUT_W + 1)'(m_q[l]);
      if (dsp.dsp_acc_load) begin
        p_d[l] = OUT_W'(m_q[l]);
      end else begin
        p_d[l]   = acc_sum[l][OUT_W-1:0];
        ovf_d[l] = ovf_q[l] | acc_sum[l][OUT_W];
      end
`else
      p_d[l] = OUT_W'(m_q[l]);
`endif
    end
  end

  // Clear beats clock-enable: operands on a clearing edge are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      p_q     <= '0;
      vpipe_q <= '0;
    end else if (dsp.dsp_clr) begin
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      p_q     <= '0;
      vpipe_q <= '0;
    end else if (dsp.dsp_ce) begin
      a_q     <= dsp.dsp_a0;
      b_q     <= dsp.dsp_b0;
      m_q     <= m_d;
      p_q     <= p_d;
      vpipe_q <= {vpipe_q[1:0], 1'b1};
    end
  end

`ifdef DSP_ACC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= '0;
    end else if (dsp.dsp_clr) begin
      ovf_q <= '0;
    end else if (dsp.dsp_ce) begin
      ovf_q <= ovf_d;
    end
  end

  assign dsp.dsp_acc_ovf = ovf_q;
`endif

  assign dsp.dsp_out       = p_q;
  assign dsp.dsp_out_valid = vpipe_q[2];

endmodule

// File: tb/tb_dsp_mult_lane_array.sv
// Self-checking bench for dsp_mult_lane_array: a scoreboard queue receives the per-lane
// products on every enabled edge and releases them three enabled edges later.
module tb_dsp_mult_lane_array;

  localparam int unsigned NUM_LANES = 5;
  localparam int unsigned A_W       = 18;
  localparam int unsigned B_W       = 18;
  localparam int unsigned OUT_W     = 37;
  localparam int unsigned M_W       = A_W + B_W;

  typedef logic [NUM_LANES-1:0][M_W-1:0] prod_t;

  logic clk;
  logic rst;

  dsp_mult_lane_array_if #(
    .NUM_LANES(NUM_LANES), .A_W(A_W), .B_W(B_W), .OUT_W(OUT_W)
  ) bus ();

  dsp_mult_lane_array #(
    .NUM_LANES(NUM_LANES), .A_W(A_W), .B_W(B_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dsp(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [NUM_LANES-1:0][A_W-1:0]   a_drv;
  logic [NUM_LANES-1:0][B_W-1:0]   b_drv;
  prod_t                           sb_q[$];
  logic [NUM_LANES-1:0][OUT_W-1:0] exp_out;
  logic                            exp_valid;
`ifdef DSP_ACC_EN
  logic                            load_drv;
  logic [NUM_LANES-1:0]            exp_ovf;
`endif

  task automatic sb_flush();
    sb_q.delete();
    exp_out   = '0;
    exp_valid = 1'b0;
`ifdef DSP_ACC_EN
    exp_ovf = '0;
`endif
  endtask

  // Drive one cycle, then advance the scoreboard to what the outputs should show.
  task automatic step(input logic ce, input logic clr);
    prod_t prod;
    prod_t m;
`ifdef DSP_ACC_EN
    logic [OUT_W:0] sum;
`endif
    @(negedge clk);
    bus.dsp_ce  = ce;
    bus.dsp_clr = clr;
    bus.dsp_a0  = a_drv;
    bus.dsp_b0  = b_drv;
`ifdef DSP_ACC_EN
    bus.dsp_acc_load = load_drv;
`endif
    @(posedge clk);
    #1;
    if (clr) begin
      sb_flush();
    end else if (ce) begin
      for (int l = 0; l < NUM_LANES; l++) prod[l] = M_W'(a_drv[l]) * M_W'(b_drv[l]);
      sb_q.push_back(prod);
      if (sb_q.size() == 3) begin
        m = sb_q.pop_front();
        exp_valid = 1'b1;
        for (int l = 0; l < NUM_LANES; l++) begin
`ifdef DSP_ACC_EN
          if (load_drv) begin
            exp_out[l] = OUT_W'(m[l]);
          end else begin
            sum = {1'b0, exp_out[l]} + (OUT_W + 1)'(m[l]);
            exp_out[l] = sum[OUT_W-1:0];
            if (sum[OUT_W]) exp_ovf[l] = 1'b1;
          end
`else
          exp_out[l] = OUT_W'(m[l]);
`endif
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.dsp_ce  = 1'b0;
    bus.dsp_clr = 1'b0;
    a_drv = '0;
    b_drv = '0;
    bus.dsp_a0 = '0;
    bus.dsp_b0 = '0;
`ifdef DSP_ACC_EN
    load_drv = 1'b1;
    bus.dsp_acc_load = 1'b1;
`endif
    sb_flush();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.dsp_out !== '0 || bus.dsp_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state out=%h valid=%b expected out=0 valid=0",
               bus.dsp_out, bus.dsp_out_valid);
    end
`ifdef DSP_ACC_EN
    checks++;
    if (bus.dsp_acc_ovf !== '0) begin
      errors++;
      $display("FAIL reset_ovf ovf=%b expected 0", bus.dsp_acc_ovf);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    a_drv = '0;
    b_drv = '0;
    a_drv[0] = 18'd200;
    b_drv[0] = 18'd3;
    for (int s = 1; s <= 3; s++) begin
      step(1'b1, 1'b0);
      checks++;
      if (bus.dsp_out !== exp_out || bus.dsp_out_valid !== exp_valid) begin
        errors++;
        $display("FAIL basic_edge%0d out=%h valid=%b expected out=%h valid=%b", s,
                 bus.dsp_out, bus.dsp_out_valid, exp_out, exp_valid);
      end
    end
    checks++;
    if (bus.dsp_out[0] !== 37'd600 || bus.dsp_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_600 out0=%0d valid=%b expected 600 valid=1",
               bus.dsp_out[0], bus.dsp_out_valid);
    end
  endtask

  task automatic test_lanes();
    a_drv = {NUM_LANES{18'h3ffff}};
    b_drv = {NUM_LANES{18'h3ffff}};
    repeat (3) step(1'b1, 1'b0);
    for (int l = 0; l < NUM_LANES; l++) begin
      checks++;
      if (bus.dsp_out[l] !== 37'd68718952449 || bus.dsp_out[l][OUT_W-1] !== 1'b0) begin
        errors++;
        $display("FAIL lanes_max lane%0d out=%0d expected 68718952449 (bit36=0)", l,
                 bus.dsp_out[l]);
      end
    end
    for (int l = 0; l < NUM_LANES; l++) begin
      a_drv[l] = 18'(l + 1);
      b_drv[l] = 18'd7;
    end
    for (int s = 1; s <= 3; s++) begin
      step(1'b1, 1'b0);
      checks++;
      if (bus.dsp_out !== exp_out || bus.dsp_out_valid !== exp_valid) begin
        errors++;
        $display("FAIL lanes_edge%0d out=%h valid=%b expected out=%h valid=%b", s,
                 bus.dsp_out, bus.dsp_out_valid, exp_out, exp_valid);
      end
    end
    for (int l = 0; l < NUM_LANES; l++) begin
      checks++;
      if (bus.dsp_out[l] !== 37'(7 * (l + 1))) begin
        errors++;
        $display("FAIL lanes_indep lane%0d out=%0d expected %0d", l, bus.dsp_out[l],
                 7 * (l + 1));
      end
    end
  endtask

  task automatic test_stall();
    b_drv = {NUM_LANES{18'd10}};
    for (int k = 1; k <= 8; k++) begin
      a_drv = {NUM_LANES{18'(k <= 6 ? k : 0)}};
      step(1'b1, 1'b0);
      checks++;
      if (bus.dsp_out !== exp_out || bus.dsp_out_valid !== exp_valid) begin
        errors++;
        $display("FAIL stall_stream%0d out=%h expected %h", k, bus.dsp_out, exp_out);
      end
      if (k >= 3) begin
        checks++;
        if (bus.dsp_out[0] !== 37'(10 * (k - 2))) begin
          errors++;
          $display("FAIL stall_order%0d out0=%0d expected %0d", k, bus.dsp_out[0],
                   10 * (k - 2));
        end
      end
      if (k == 3) begin
        for (int s = 0; s < 5; s++) begin
          a_drv = {NUM_LANES{18'd99}};
          step(1'b0, 1'b0);
          checks++;
          if (bus.dsp_out[0] !== 37'd10 || bus.dsp_out !== exp_out ||
              bus.dsp_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_frozen%0d out0=%0d valid=%b expected 10 valid=1", s,
                     bus.dsp_out[0], bus.dsp_out_valid);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    a_drv = {NUM_LANES{18'd11}};
    b_drv = {NUM_LANES{18'd13}};
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus.dsp_ce = 1'b0;
    #1;
    sb_flush();
    checks++;
    if (bus.dsp_out !== '0 || bus.dsp_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_async out=%h valid=%b expected out=0 valid=0",
               bus.dsp_out, bus.dsp_out_valid);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    a_drv = {NUM_LANES{18'd6}};
    b_drv = {NUM_LANES{18'd7}};
    for (int s = 1; s <= 3; s++) begin
      step(1'b1, 1'b0);
      checks++;
      if (bus.dsp_out !== exp_out || bus.dsp_out_valid !== exp_valid) begin
        errors++;
        $display("FAIL rst_refill%0d out=%h valid=%b expected out=%h valid=%b", s,
                 bus.dsp_out, bus.dsp_out_valid, exp_out, exp_valid);
      end
    end
    checks++;
    if (bus.dsp_out[NUM_LANES-1] !== 37'd42 || bus.dsp_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_refill_val out=%0d valid=%b expected 42 valid=1",
               bus.dsp_out[NUM_LANES-1], bus.dsp_out_valid);
    end
  endtask

  task automatic test_clear();
    a_drv = {NUM_LANES{18'd77}};
    b_drv = {NUM_LANES{18'd3}};
    step(1'b1, 1'b1);
    checks++;
    if (bus.dsp_out !== '0 || bus.dsp_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_zero out=%h valid=%b expected out=0 valid=0",
               bus.dsp_out, bus.dsp_out_valid);
    end
    a_drv = {NUM_LANES{18'd4}};
    b_drv = {NUM_LANES{18'd5}};
    for (int s = 1; s <= 3; s++) begin
      step(1'b1, 1'b0);
      checks++;
      if (bus.dsp_out !== exp_out || bus.dsp_out_valid !== exp_valid) begin
        errors++;
        $display("FAIL clr_refill%0d out=%h valid=%b expected out=%h valid=%b", s,
                 bus.dsp_out, bus.dsp_out_valid, exp_out, exp_valid);
      end
    end
    checks++;
    if (bus.dsp_out[2] !== 37'd20) begin
      errors++;
      $display("FAIL clr_discard out=%0d expected 20", bus.dsp_out[2]);
    end
  endtask

`ifdef DSP_ACC_EN
  task automatic test_acc();
    load_drv = 1'b1;
    step(1'b0, 1'b1);
    a_drv = {NUM_LANES{18'd10}};
    b_drv = {NUM_LANES{18'd10}};
    step(1'b1, 1'b0);
    a_drv = {NUM_LANES{18'd5}};
    b_drv = {NUM_LANES{18'd4}};
    step(1'b1, 1'b0);
    a_drv = '0;
    b_drv = '0;
    step(1'b1, 1'b0);
    checks++;
    if (bus.dsp_out[0] !== 37'd100 || bus.dsp_out !== exp_out) begin
      errors++;
      $display("FAIL acc_load out0=%0d expected 100", bus.dsp_out[0]);
    end
    load_drv = 1'b0;
    step(1'b1, 1'b0);
    checks++;
    if (bus.dsp_out[0] !== 37'd120 || bus.dsp_out !== exp_out) begin
      errors++;
      $display("FAIL acc_add out0=%0d expected 120", bus.dsp_out[0]);
    end
    step(1'b0, 1'b1);
    a_drv = {NUM_LANES{18'h3ffff}};
    b_drv = {NUM_LANES{18'h3ffff}};
    for (int s = 1; s <= 5; s++) begin
      if (s == 4) begin
        a_drv = '0;
        b_drv = '0;
      end
      step(1'b1, 1'b0);
      checks++;
      if (bus.dsp_out !== exp_out || bus.dsp_acc_ovf !== exp_ovf) begin
        errors++;
        $display("FAIL acc_wrap_edge%0d out=%h ovf=%b expected out=%h ovf=%b", s,
                 bus.dsp_out, bus.dsp_acc_ovf, exp_out, exp_ovf);
      end
    end
    checks++;
    if (bus.dsp_out[1] !== 37'd68717903875 || bus.dsp_acc_ovf !== {NUM_LANES{1'b1}}) begin
      errors++;
      $display("FAIL acc_wrap out1=%0d ovf=%b expected 68717903875 ovf=all1",
               bus.dsp_out[1], bus.dsp_acc_ovf);
    end
    step(1'b1, 1'b0);
    checks++;
    if (bus.dsp_acc_ovf !== {NUM_LANES{1'b1}}) begin
      errors++;
      $display("FAIL acc_sticky ovf=%b expected all1", bus.dsp_acc_ovf);
    end
    step(1'b0, 1'b1);
    checks++;
    if (bus.dsp_acc_ovf !== '0 || bus.dsp_out !== '0) begin
      errors++;
      $display("FAIL acc_clr ovf=%b out=%h expected 0", bus.dsp_acc_ovf, bus.dsp_out);
    end
    load_drv = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_lanes();
    test_stall();
    test_reset_mid();
    test_clear();
`ifdef DSP_ACC_EN
    test_acc();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
